rgb_pwm_cmd_fsm: RTL and testbench

Multi-channel successor to the single-LED RGB command FSM. Parses an ASCII byte stream from the UART receiver and drives NUM_CH RGB LEDs with per-colour PWM duty instead of on/off. Sits between the UART RX byte output and the LED pins on the FDA LED test board.

---
 rtl/rgb_cmd_pkg.sv | 49 ++++
 rtl/rgb_pwm_channel.sv | 36 +++
 rtl/rgb_pwm_cmd_fsm.sv | 171 +++++++++++++++++
 tb/tb_rgb_pwm_cmd_fsm.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_cmd_pkg.sv
// Shared definitions for the RGB PWM command parser: ASCII codes, parser
// states, colour bit positions and the hex-digit decoder.
package rgb_cmd_pkg;

  localparam logic [7:0] ASC_R_UC = 8'h52;
  localparam logic [7:0] ASC_R_LC = 8'h72;
  localparam logic [7:0] ASC_G_UC = 8'h47;
  localparam logic [7:0] ASC_G_LC = 8'h67;
  localparam logic [7:0] ASC_B_UC = 8'h42;
  localparam logic [7:0] ASC_B_LC = 8'h62;
  localparam logic [7:0] ASC_X    = 8'h58;
  localparam logic [7:0] ASC_U    = 8'h55;
  localparam logic [7:0] ASC_CR   = 8'h0D;
  localparam logic [7:0] ASC_LF   = 8'h0A;
  localparam logic [7:0] ASC_SP   = 8'h20;
  localparam logic [7:0] ASC_0    = 8'h30;
  localparam logic [7:0] ASC_9    = 8'h39;

  typedef enum logic [1:0] {
    IDLE,
    HEX_HI,
    HEX_LO
  } state_e;

  localparam logic [1:0] COL_R = 2'd2;
  localparam logic [1:0] COL_G = 2'd1;
  localparam logic [1:0] COL_B = 2'd0;

  typedef struct packed {
    logic       valid;
    logic [3:0] nib;
  } hex_t;

  function automatic hex_t hex_decode(input logic [7:0] c);
    hex_t h;
    h.valid = 1'b1;
    h.nib   = '0;
    if (c >= ASC_0 && c <= ASC_9) begin
      h.nib = c[3:0];
    end else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66)) begin
      // 'A'/'a' have low nibble 1, so +9 maps them onto 10..15
      h.nib = c[3:0] + 4'd9;
    end else begin
      h.valid = 1'b0;
    end
    return h;
  endfunction

endpackage

// File: rtl/rgb_pwm_channel.sv
// One RGB LED: compares the shared PWM counter against three duties and
// registers the resulting drive bits.
module rgb_pwm_channel
  import rgb_cmd_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [PWM_BITS-1:0] cnt_i,
  input  logic [PWM_BITS-1:0] duty_r_i,
  input  logic [PWM_BITS-1:0] duty_g_i,
  input  logic [PWM_BITS-1:0] duty_b_i,
  output logic [2:0]          rgb_o
);

  logic [2:0] rgb_q, rgb_d;

  always_comb begin
    rgb_d        = '0;
    rgb_d[COL_R] = (cnt_i < duty_r_i);
    rgb_d[COL_G] = (cnt_i < duty_g_i);
    rgb_d[COL_B] = (cnt_i < duty_b_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign rgb_o = rgb_q;

endmodule

// File: rtl/rgb_pwm_cmd_fsm.sv
// ASCII command parser driving NUM_CH RGB LEDs with per-colour PWM duty.
// Define RGB_PWM_SHADOW_EN for shadowed duties loaded at counter wrap or by 'U'.
module rgb_pwm_cmd_fsm
  import rgb_cmd_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned PRESCALE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cmd_valid_i,
  input  logic [7:0]            cmd_i,
  output logic [3*NUM_CH-1:0]   rgb_o,
  output logic                  err_o,
  output logic                  busy_o
);

  localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0]    PRE_MAX  = PRE_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX  = PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [3:0]          NUM_CH_L = 4'(NUM_CH);

  typedef logic [PWM_BITS-1:0] duty_t;

  state_e                         state_q, state_d;
  logic [3:0]                     chan_q, chan_d;
  logic [1:0]                     col_q, col_d;
  logic [3:0]                     nib_q, nib_d;
  logic                           err_q, err_d;
  logic [3*NUM_CH-1:0][PWM_BITS-1:0] wr_q, wr_d;
  logic [3*NUM_CH-1:0][PWM_BITS-1:0] act;
  logic [PRE_W-1:0]               pre_q, pre_d;
  duty_t                          cnt_q, cnt_d;
  logic                           step, wrap;
  hex_t                           hx;
  duty_t                          wval;
`ifdef RGB_PWM_SHADOW_EN
  logic                           load_now;
`endif

  always_comb begin
    step  = (pre_q == PRE_MAX);
    wrap  = step && (cnt_q == CNT_MAX);
    pre_d = step ? '0 : pre_q + 1'b1;
    cnt_d = cnt_q;
    if (step) cnt_d = wrap ? '0 : cnt_q + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    col_d    = col_q;
    nib_d    = nib_q;
    err_d    = 1'b0;
    wr_d     = wr_q;
    hx       = hex_decode(cmd_i);
    wval     = duty_t'({nib_q, hx.nib} >> (8 - PWM_BITS));
`ifdef RGB_PWM_SHADOW_EN
    load_now = 1'b0;
`endif
    if (cmd_valid_i) begin
      unique case (state_q)
        IDLE: begin
          if (cmd_i >= ASC_0 && cmd_i <= ASC_9) begin
            if (cmd_i[3:0] < NUM_CH_L) chan_d = cmd_i[3:0];
            else                       err_d  = 1'b1;
          end else if (cmd_i == ASC_R_UC || cmd_i == ASC_R_LC) begin
            col_d   = COL_R;
            state_d = HEX_HI;
          end else if (cmd_i == ASC_G_UC || cmd_i == ASC_G_LC) begin
            col_d   = COL_G;
            state_d = HEX_HI;
          end else if (cmd_i == ASC_B_UC || cmd_i == ASC_B_LC) begin
            col_d   = COL_B;
            state_d = HEX_HI;
          end else if (cmd_i == ASC_X) begin
            wr_d = '0;
          end else if (cmd_i == ASC_CR || cmd_i == ASC_LF || cmd_i == ASC_SP) begin
            state_d = IDLE;
`ifdef RGB_PWM_SHADOW_EN
          end else if (cmd_i == ASC_U) begin
            load_now = 1'b1;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
        HEX_HI: begin
          if (hx.valid) begin
            nib_d   = hx.nib;
            state_d = HEX_LO;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
        HEX_LO: begin
          state_d = IDLE;
          if (hx.valid) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              for (int unsigned k = 0; k < 3; k++) begin
                if (chan_q == 4'(c) && col_q == 2'(k)) wr_d[3*c+k] = wval;
              end
            end
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      chan_q  <= '0;
      col_q   <= COL_R;
      nib_q   <= '0;
      err_q   <= 1'b0;
      wr_q    <= '0;
      pre_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      col_q   <= col_d;
      nib_q   <= nib_d;
      err_q   <= err_d;
      wr_q    <= wr_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef RGB_PWM_SHADOW_EN
  logic [3*NUM_CH-1:0][PWM_BITS-1:0] act_q;

  // Loading from wr_d lets a write landing on the wrap edge take effect at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      act_q <= '0;
    end else if (wrap || load_now) begin
      act_q <= wr_d;
    end
  end

  assign act = act_q;
`else
  assign act = wr_q;
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rgb_pwm_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .cnt_i    (cnt_q),
      .duty_r_i (act[3*c+2]),
      .duty_g_i (act[3*c+1]),
      .duty_b_i (act[3*c]),
      .rgb_o    (rgb_o[3*c +: 3])
    );
  end

  assign err_o  = err_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_rgb_pwm_cmd_fsm.sv
// Self-checking bench for rgb_pwm_cmd_fsm with a byte-level protocol model.
module tb_rgb_pwm_cmd_fsm;

  localparam int NCH    = 4;
  localparam int PERIOD = 255;
`ifdef RGB_PWM_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cmd_valid = 1'b0;
  logic [7:0]        cmd = '0;
  logic [3*NCH-1:0]  rgb_o;
  logic              err_o, busy_o;

  int nvec = 0;
  int nerr = 0;

  rgb_pwm_cmd_fsm #(
    .NUM_CH   (NCH),
    .PWM_BITS (8),
    .PRESCALE (1)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_i       (cmd),
    .rgb_o       (rgb_o),
    .err_o       (err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  // Model: duties indexed 3*channel + bit offset (R=2, G=1, B=0)
  int wr_m[3*NCH];
  int act_m[3*NCH];
  int mode_m;
  int hi_m;
  int sel_m;
  int col_m;
  int cyc;
  logic [3*NCH-1:0] exp_rgb;
  logic             exp_err;
  logic             exp_busy;

  function automatic int hexv(input logic [7:0] b);
    if (b >= "0" && b <= "9") return int'(b) - 48;
    if (b >= "A" && b <= "F") return int'(b) - 55;
    if (b >= "a" && b <= "f") return int'(b) - 87;
    return -1;
  endfunction

  task automatic reset_model();
    foreach (wr_m[i]) begin
      wr_m[i]  = 0;
      act_m[i] = 0;
    end
    mode_m = 0; hi_m = 0; sel_m = 0; col_m = 2; cyc = 0;
    exp_rgb = '0; exp_err = 1'b0; exp_busy = 1'b0;
  endtask

  task automatic step(input bit v, input logic [7:0] b);
    int  h;
    bit  load;
    @(negedge clk);
    cmd_valid = v;
    cmd       = b;
    @(posedge clk);
    for (int i = 0; i < 3*NCH; i++) exp_rgb[i] = ((cyc % PERIOD) < act_m[i]);
    exp_err = 1'b0;
    load    = 1'b0;
    h       = hexv(b);
    if (v) begin
      if (mode_m == 0) begin
        if (b >= "0" && b <= "9") begin
          if (int'(b) - 48 < NCH) sel_m = int'(b) - 48;
          else exp_err = 1'b1;
        end else if (b == "R" || b == "r") begin col_m = 2; mode_m = 1; end
        else if (b == "G" || b == "g") begin col_m = 1; mode_m = 1; end
        else if (b == "B" || b == "b") begin col_m = 0; mode_m = 1; end
        else if (b == "X") begin foreach (wr_m[i]) wr_m[i] = 0; end
        else if (b == 8'h0D || b == 8'h0A || b == 8'h20) begin end
        else if (b == "U" && SHADOW) load = 1'b1;
        else exp_err = 1'b1;
      end else if (mode_m == 1) begin
        if (h >= 0) begin hi_m = h; mode_m = 2; end
        else begin exp_err = 1'b1; mode_m = 0; end
      end else begin
        if (h >= 0) wr_m[3*sel_m + col_m] = hi_m * 16 + h;
        else exp_err = 1'b1;
        mode_m = 0;
      end
    end
    cyc++;
    if (!SHADOW || (cyc % PERIOD == 0) || load) act_m = wr_m;
    exp_busy = (mode_m != 0);
    #1;
  endtask

  task automatic hold_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    cmd_valid = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    if ({rgb_o, err_o, busy_o} !== '0) begin
      nerr++; $display("FAIL reset_hold rgb=%h err=%b busy=%b want all 0", rgb_o, err_o, busy_o);
    end
    nvec++;
    repeat (2) @(posedge clk);
    release_reset();
    for (int i = 0; i < 600; i++) begin
      step(1'b0, 8'h00);
      if ({rgb_o, err_o, busy_o} !== {exp_rgb, exp_err, exp_busy}) begin
        nerr++; $display("FAIL idle cyc=%0d rgb=%h err=%b busy=%b want %h %b %b", cyc, rgb_o, err_o, busy_o, exp_rgb, exp_err, exp_busy);
      end
      nvec++;
    end
  endtask

  task automatic test_one_channel();
    string s = "1R80";
    int    highs = 0;
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i]);
      if ({rgb_o, err_o, busy_o} !== {exp_rgb, exp_err, exp_busy}) begin
        nerr++; $display("FAIL one_ch_cmd cyc=%0d rgb=%h err=%b busy=%b want %h %b %b", cyc, rgb_o, err_o, busy_o, exp_rgb, exp_err, exp_busy);
      end
      nvec++;
    end
    step(1'b0, 8'h00);
    for (int i = 0; i < PERIOD; i++) begin
      step(1'b0, 8'h00);
      highs += int'(rgb_o[5]);
      if ({rgb_o, err_o, busy_o} !== {exp_rgb, exp_err, exp_busy}) begin
        nerr++; $display("FAIL one_ch_run cyc=%0d rgb=%h want %h", cyc, rgb_o, exp_rgb);
      end
      nvec++;
    end
    if (highs !== 128) begin
      nerr++; $display("FAIL one_ch_duty highs=%0d want 128", highs);
    end
    nvec++;
  endtask

  task automatic test_full_on();
    string s = "2GFF2B00";
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
    step(1'b0, 8'h00);
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 8'h00);
      if (rgb_o[7] !== 1'b1 || rgb_o[6] !== 1'b0) begin
        nerr++; $display("FAIL full_on cyc=%0d g=%b b=%b want 1 0", cyc, rgb_o[7], rgb_o[6]);
      end
      nvec++;
      if ({rgb_o, err_o, busy_o} !== {exp_rgb, exp_err, exp_busy}) begin
        nerr++; $display("FAIL full_on_model cyc=%0d rgb=%h want %h", cyc, rgb_o, exp_rgb);
      end
      nvec++;
    end
  endtask

  task automatic test_bad_hex();
    string s = "0R8Z";
    int    highs = 0;
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      nerr++; $display("FAIL bad_hex_err err=%b busy=%b want 1 0", err_o, busy_o);
    end
    nvec++;
    step(1'b0, 8'h00);
    if (err_o !== 1'b0) begin
      nerr++; $display("FAIL bad_hex_pulse err=%b want 0", err_o);
    end
    nvec++;
    s = "R10";
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
    step(1'b0, 8'h00);
    for (int i = 0; i < PERIOD; i++) begin
      step(1'b0, 8'h00);
      highs += int'(rgb_o[2]);
      if ({rgb_o, err_o, busy_o} !== {exp_rgb, exp_err, exp_busy}) begin
        nerr++; $display("FAIL bad_hex_run cyc=%0d rgb=%h want %h", cyc, rgb_o, exp_rgb);
      end
      nvec++;
    end
    if (highs !== 16) begin
      nerr++; $display("FAIL bad_hex_duty highs=%0d want 16", highs);
    end
    nvec++;
  endtask

  task automatic test_bad_chan();
    string s = "7RFF";
    for (int i = 0; i < s.len(); i++) begin
      step(1'b1, s[i]);
      if ({rgb_o, err_o, busy_o} !== {exp_rgb, exp_err, exp_busy}) begin
        nerr++; $display("FAIL bad_chan cyc=%0d rgb=%h err=%b busy=%b want %h %b %b", cyc, rgb_o, err_o, busy_o, exp_rgb, exp_err, exp_busy);
      end
      nvec++;
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 8'h00);
      if (rgb_o[2] !== 1'b1 || rgb_o[11] !== 1'b0) begin
        nerr++; $display("FAIL bad_chan_sel ch0r=%b ch3r=%b want 1 0", rgb_o[2], rgb_o[11]);
      end
      nvec++;
    end
  endtask

  task automatic test_reset_mid();
    string s = "RF";
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
    if (busy_o !== 1'b1) begin
      nerr++; $display("FAIL mid_busy busy=%b want 1", busy_o);
    end
    nvec++;
    hold_reset();
    #1;
    if ({rgb_o, err_o, busy_o} !== '0) begin
      nerr++; $display("FAIL mid_reset rgb=%h err=%b busy=%b want all 0", rgb_o, err_o, busy_o);
    end
    nvec++;
    release_reset();
    s = "0F";
    for (int i = 0; i < 300; i++) begin
      step(i < 2, s[i % 2]);
      if ({rgb_o, err_o, busy_o} !== {exp_rgb, exp_err, exp_busy}) begin
        nerr++; $display("FAIL after_reset cyc=%0d rgb=%h err=%b busy=%b want %h %b %b", cyc, rgb_o, err_o, busy_o, exp_rgb, exp_err, exp_busy);
      end
      nvec++;
    end
  endtask

  task automatic test_back_to_back();
    string pool = "0123456789RrGgBbAaCcDdEeFfXZUqx \r\nRGB0123";
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) != 0, pool[$urandom_range(0, pool.len() - 1)]);
      if ({rgb_o, err_o, busy_o} !== {exp_rgb, exp_err, exp_busy}) begin
        nerr++; $display("FAIL random cyc=%0d rgb=%h err=%b busy=%b want %h %b %b", cyc, rgb_o, err_o, busy_o, exp_rgb, exp_err, exp_busy);
      end
      nvec++;
    end
  endtask

  initial begin
    reset_model();
    test_reset();
    test_one_channel();
    test_full_on();
    test_bad_hex();
    test_bad_chan();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
